serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Inverse of the combinational adder block: recovers operand b from a (WIDTH+1)-bit sum and the known operand a, i.e. b = sum - a.
- Bit-serial: one difference bit per clock, LSB first, ripple borrow held in a flop. Trades latency for area.
- Valid/ready handshake on both sides.
- Sits downstream of adder outputs in checker/decoder paths where one operand must be reconstructed.

Parameters:
WIDTH, 4, operand width; sum input is WIDTH+1 bits, result b is WIDTH bits.

Ports:
clk  input  1  sole clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  sum/a valid.
in_ready  output  1  block can accept; high only in IDLE.
sum  input  WIDTH+1  minuend (adder output format).
a  input  WIDTH  subtrahend, zero-extended to WIDTH+1 internally.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
b  output  WIDTH  recovered operand.
err  output  1  result not representable in WIDTH bits.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, b=0, err=0; internal shift registers, bit counter and borrow cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch sum and {1'b0,a}, clear borrow and counter, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge processes bit i, for i = 0..WIDTH:
    - d_i = s_i ^ a_i ^ borrow
    - borrow' = (~s_i & a_i) | (~(s_i ^ a_i) & borrow)
  - d_i shifts into the result register; the counter increments.
  - After the edge processing bit WIDTH, go to DONE.
- Latency: out_valid rises exactly WIDTH+1 clocks after the accepting edge (5 for WIDTH=4).
- DONE:
  - out_valid=1, in_ready=0.
  - b = d[WIDTH-1:0].
  - err = final_borrow | d_WIDTH. final_borrow means sum < a; d_WIDTH means difference >= 2^WIDTH.
  - b and err are registered and stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: go to IDLE, out_valid=0; b and err hold their last value.
- No combinational ready/valid paths:
  - in_ready depends only on state.
  - A new input cannot be accepted in the same cycle as the output handshake.
  - Minimum spacing between accepts is WIDTH+3 clocks.
- Arithmetic is modular in WIDTH+1 bits; b is the low WIDTH bits of (sum - a) mod 2^(WIDTH+1).
- Reset mid-RUN or mid-DONE:
  - Transaction aborted; no out_valid is produced for it.
  - All outputs return to reset values immediately (asynchronous).
- Changes on sum/a after acceptance have no effect.

Optional Feature:
SERIAL_SUB_SATURATE_EN
- Defined, when err=1:
  - b = 0 if final_borrow (sum < a).
  - b = {WIDTH{1'b1}} if d_WIDTH set without borrow.
  - err still asserted.
  - Applied when entering DONE; latency unchanged.
- Undefined: b = raw modular low WIDTH bits; err behaviour identical.

Test Plan:
- sum=9, a=3, out_ready=1 -> out_valid exactly 5 clocks after accept; b=6, err=0; in_ready returns 1 one clock after the out handshake.
- sum=2, a=5 -> err=1; b=13 without macro, b=0 with SERIAL_SUB_SATURATE_EN.
- sum=31, a=0 -> err=1, b=15 in both builds. Also sum=16, a=15 -> b=1, err=0.
- Backpressure on sum=12, a=4: hold out_ready=0 for 3 clocks after out_valid -> b=8, err=0 stable, in_ready=0; toggling in_valid with other data changes nothing.
- Reset asserted 2 clocks into RUN for sum=20, a=7 -> out_valid=0, in_ready=1, b=0, err=0 immediately. Then sum=20, a=7 -> b=13, err=0.
- Back-to-back with in_valid held high: sum=16, a=15 then sum=0, a=0 -> results 1 then 0, err=0 both; second accept no earlier than WIDTH+3 clocks after the first.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake bundle for serial_subtractor: operand input channel and result output channel.
// The master side (producer/consumer) drives inputs; the slave side is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] b;
    logic             err;

    modport master (
        output in_valid, sum, a, out_ready,
        input  in_ready, out_valid, b, err
    );

    modport slave (
        input  in_valid, sum, a, out_ready,
        output in_ready, out_valid, b, err
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor recovering b = sum - a, one difference bit per clock, LSB first.
// Optional macro SERIAL_SUB_SATURATE_EN clamps b to 0 / all-ones when the result overflows.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus,
    output logic [1:0]           dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready and out_valid are pure functions of the state register, so neither
    // channel has a combinational path from the opposite side.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH:0]   s_sr;
    logic [WIDTH:0]   a_sr;
    logic [WIDTH-1:0] d_sr;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] b_q;
    logic             err_q;

    logic             s_bit;
    logic             a_bit;
    logic             d_bit;
    logic             borrow_nx;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] b_final;
    logic             err_final;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- one serial bit of the subtraction ----------------
    always_comb begin
        s_bit     = s_sr[0];
        a_bit     = a_sr[0];
        d_bit     = s_bit ^ a_bit ^ borrow;
        borrow_nx = (~s_bit & a_bit) | (~(s_bit ^ a_bit) & borrow);
        last_bit  = (cnt == CW'(WIDTH));
        accept    = bus.in_valid && (state == IDLE);
        err_final = borrow_nx | d_bit;
`ifdef SERIAL_SUB_SATURATE_EN
        if (borrow_nx) begin
            b_final = '0;
        end else if (d_bit) begin
            b_final = '1;
        end else begin
            b_final = d_sr;
        end
`else
        b_final = d_sr;
`endif
    end

    // ---------------- datapath registers ----------------
    // d_sr collects bits 0..WIDTH-1; bit WIDTH only feeds err, so it is never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_sr   <= '0;
            a_sr   <= '0;
            d_sr   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            b_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_sr   <= bus.sum;
                        a_sr   <= {1'b0, bus.a};
                        d_sr   <= '0;
                        cnt    <= '0;
                        borrow <= 1'b0;
                    end
                end
                RUN: begin
                    s_sr   <= s_sr >> 1;
                    a_sr   <= a_sr >> 1;
                    borrow <= borrow_nx;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        b_q   <= b_final;
                        err_q <= err_final;
                    end else begin
                        d_sr <= WIDTH'({d_bit, d_sr} >> 1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.b         = b_q;
    assign bus.err       = err_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard of {err,b} pushed at accept,
// popped when the result is presented.
module tb_serial_subtractor;
  localparam int W = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;
  logic [W:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: returns {err, b} ----------------
  function automatic logic [W:0] model(input logic [W:0] s, input logic [W-1:0] av);
    logic [W:0]   diff;
    logic         brw;
    logic         er;
    logic [W-1:0] bb;
    diff = s - {1'b0, av};
    brw  = (s < {1'b0, av});
    er   = brw | diff[W];
    bb   = diff[W-1:0];
`ifdef SERIAL_SUB_SATURATE_EN
    if (brw) bb = '0;
    else if (diff[W]) bb = '1;
`endif
    return {er, bb};
  endfunction

  // ---------------- driver tasks ----------------
  // Present operands at a negedge, wait for in_ready, let one edge accept, then scramble inputs.
  task automatic accept(input logic [W:0] s, input logic [W-1:0] av, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sum      = s;
    bus.a        = av;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    if (ok) exp_q.push_back(model(s, av));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sum      = (W + 1)'($urandom);
    bus.a        = W'($urandom);
  endtask

  // Count edges from the accepting edge until out_valid is seen (bounded).
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  // One output handshake edge, starting and ending at a negedge.
  task automatic take_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sum = '0;
    bus.a   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.b !== '0 || bus.err !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b b=%0d err=%b state=%0d, want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.b, bus.err, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W:0]   s_tab[8];
    logic [W-1:0] a_tab[8];
    logic [W:0]   exp;
    bit           ok;
    int           cyc;
    s_tab[0] = 5'd9;  a_tab[0] = 4'd3;
    s_tab[1] = 5'd2;  a_tab[1] = 4'd5;
    s_tab[2] = 5'd31; a_tab[2] = 4'd0;
    s_tab[3] = 5'd16; a_tab[3] = 4'd15;
    for (int i = 4; i < 8; i++) begin
      s_tab[i] = (W + 1)'($urandom_range(0, 31));
      a_tab[i] = W'($urandom_range(0, 15));
    end
    for (int i = 0; i < 8; i++) begin
      accept(s_tab[i], a_tab[i], ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL basic_accept[%0d]: in_ready never rose", i);
        continue;
      end
      wait_out(cyc);
      checks++;
      if (cyc !== W + 1) begin
        failures++;
        $display("FAIL basic_latency[%0d]: got %0d clocks, want %0d", i, cyc, W + 1);
      end
      exp = exp_q.pop_front();
      checks++;
      if ({bus.err, bus.b} !== exp) begin
        failures++;
        $display("FAIL basic_result[%0d] sum=%0d a=%0d: err=%b b=%0d, want err=%b b=%0d",
                 i, s_tab[i], a_tab[i], bus.err, bus.b, exp[W], exp[W-1:0]);
      end
      take_out();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || {bus.err, bus.b} !== exp) begin
        failures++;
        $display("FAIL basic_release[%0d]: in_ready=%b out_valid=%b err=%b b=%0d, want 1 0 %b %0d",
                 i, bus.in_ready, bus.out_valid, bus.err, bus.b, exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp;
    bit         ok;
    int         cyc;
    accept(5'd12, 4'd4, ok);
    wait_out(cyc);
    checks++;
    if (!ok || cyc !== W + 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL bp_start: ok=%b latency=%0d queue=%0d, want 1 %0d 1", ok, cyc, exp_q.size(), W + 1);
    end
    exp = (exp_q.size() != 0) ? exp_q[0] : '0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.sum      = (W + 1)'($urandom_range(0, 31));
      bus.a        = W'($urandom_range(0, 15));
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.err, bus.b} !== exp || dbg_state !== 2'd2) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b err=%b b=%0d state=%0d, want 1 0 %b %0d 2",
                 i, bus.out_valid, bus.in_ready, bus.err, bus.b, dbg_state, exp[W], exp[W-1:0]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    exp = exp_q.pop_front();
    take_out();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || {bus.err, bus.b} !== exp) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b err=%b b=%0d, want 1 0 %b %0d",
               bus.in_ready, bus.out_valid, bus.err, bus.b, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W:0] exp;
    bit         ok;
    bit         seen;
    int         cyc;
    accept(5'd20, 4'd7, ok);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.b !== '0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_run: out_valid=%b in_ready=%b b=%0d err=%b, want 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.b, bus.err);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (2 * W + 4) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_abort: out_valid=1 after aborted transaction, want 0");
    end
    accept(5'd20, 4'd7, ok);
    wait_out(cyc);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || cyc !== W + 1 || {bus.err, bus.b} !== exp) begin
      failures++;
      $display("FAIL rst_recover: ok=%b latency=%0d err=%b b=%0d, want 1 %0d %b %0d",
               ok, cyc, bus.err, bus.b, W + 1, exp[W], exp[W-1:0]);
    end
    take_out();
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp;
    int         cyc;
    int         second;
    int         got;
    int         n;
    cyc = 0;
    second = -1;
    got = 0;
    n = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sum       = 5'd16;
    bus.a         = 4'd15;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp_q.push_back(model(5'd16, 4'd15));
    @(posedge clk);
    @(negedge clk);
    bus.sum = '0;
    bus.a   = '0;
    while (got < 2 && cyc < 60) begin
      if (bus.out_valid) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : {1'b1, {W{1'b1}}};
        checks++;
        if ({bus.err, bus.b} !== exp) begin
          failures++;
          $display("FAIL b2b_result[%0d]: err=%b b=%0d, want err=%b b=%0d",
                   got, bus.err, bus.b, exp[W], exp[W-1:0]);
        end
        got++;
      end
      if (bus.in_ready && bus.in_valid && second < 0) begin
        second = cyc + 1;
        exp_q.push_back(model(5'd0, 4'd0));
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (second >= 0) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (got != 2 || second < W + 3) begin
      failures++;
      $display("FAIL b2b_spacing: results=%0d second_accept=%0d clocks, want 2 and >=%0d",
               got, second, W + 3);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d results never produced, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
